keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Drives the 4x4 keypad columns and consumes the synchronized rows and the per-row
//  debounced press pulses produced by the four row debouncers.
//  Locks onto the pressed key and emits one hex key code per press, with no repeat
//  while held. Sits between the row debouncers and the display/digit-shift logic.
// PARAMETERS
//  SETTLE_CYCLES  4     cycles each column is driven before rows are sampled (>=2)
//  LOCK_TIMEOUT   255   max cycles in LOCK waiting for a debounced press pulse
//  RELEASE_CYCLES 64    consecutive all-rows-low cycles required to declare release
// PORTS
//  clk        in   1  system clock
//  nrst       in   1  asynchronous, active-low reset
//  row_sync   in   4  synchronized raw rows, active-high, bit r = row r
//  row_press  in   4  debounced press pulses, one cycle per qualified press
//  col        out  4  column drive, one-hot active-high, bit c = column c
//  key_code   out  4  hex code of last accepted key; holds until next accept
//  key_valid  out  1  one-cycle strobe; key_code is new in the same cycle
//  key_held   out  1  high while the accepted key is still pressed
// BEHAVIOUR
//  Reset (async, nrst=0): state=SCAN, col=4'b0001, key_code=0, key_valid=0,
//   key_held=0, all counters cleared. Applies immediately, including mid-press.
//  All outputs registered.
//  SCAN:
//   - Drive col; count SETTLE_CYCLES cycles.
//   - On the last cycle: if |row_sync, latch the active column and row = lowest set
//     bit of row_sync (lower index has priority), then go to LOCK.
//   - Otherwise rotate col left, 4'b1000 -> 4'b0001, and restart the count.
//  LOCK:
//   - Column frozen.
//   - row_press[lrow]=1 -> next cycle: key_valid=1, key_code=KEY_MAP[lrow][lcol],
//     key_held=1, state=PRESSED.
//   - row_press wins even if row_sync[lrow]=0 in the same cycle.
//   - Else row_sync[lrow]=0 (bounce) or timeout counter reaches LOCK_TIMEOUT
//     -> SCAN at the next column.
//   - row_press on any other row is ignored.
//  PRESSED:
//   - Column frozen; rel_cnt increments while row_sync==0.
//   - rel_cnt clears on any row high.
//   - rel_cnt==RELEASE_CYCLES-1 with rows low -> key_held=0, SCAN at the next column.
//   - Other keys pressed meanwhile are ignored; no rollover, no auto-repeat.
//  Latency: key_valid is asserted exactly 1 cycle after the accepted row_press cycle.
//  key_valid is never high in two consecutive cycles.
//  Counters are sized with $clog2(param+1) and saturate at the limit, never wrap.
//  KEY_MAP (row r, col c):  r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
// STRUCTURE
//  keypad_pkg holds:
//   - scan_state_t enum {SCAN, LOCK, PRESSED}
//   - KEY_MAP constant logic [3:0][3:0][3:0]
//   - function onehot_to_idx, 4 -> 2 bits
//  No sub-module needed: one state register, one shared settle/timeout counter,
//  one release counter. The debouncers are instantiated by the parent, one per row.
// TESTING
//  1. Reset, no keys: col cycles 0001,0010,0100,1000,0001 with SETTLE_CYCLES=4
//     dwell each; key_valid stays 0.
//  2. Hold row1 while col=0100, pulse row_press[1]: key_valid one cycle later,
//     key_code=4'h6, key_held=1; col stays 0100.
//  3. Keep key 6 held 1000 cycles: no further key_valid. Drop rows: key_held falls
//     after 64 low cycles, then col advances to 1000.
//  4. Row3 high in LOCK then low before any row_press (bounce): no key_valid;
//     returns to SCAN at the next column.
//  5. Row2+row3 high on col0001, pulse row_press[2]: key_code=4'h7
//     (lowest row wins); row_press[3] ignored.
//  6. Assert nrst=0 mid-PRESSED: col=0001, key_held=0, key_valid=0 asynchronously;
//     scanning resumes after release. LOCK timeout: row held, no press for
//     255 cycles -> SCAN.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key map and index helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    LOCK,
    PRESSED
  } scan_state_t;

  // KEY_MAP[row][col]
  localparam logic [3:0][3:0][3:0] KEY_MAP = {
    {4'hD, 4'hF, 4'h0, 4'hE},
    {4'hC, 4'h9, 4'h8, 4'h7},
    {4'hB, 4'h6, 4'h5, 4'h4},
    {4'hA, 4'h3, 4'h2, 4'h1}
  };

  function automatic logic [1:0] onehot_to_idx(
    input logic [3:0] oh
  );
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      oh[1]:   idx = 2'd1;
      oh[2]:   idx = 2'd2;
      oh[3]:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] lowest_idx(
    input logic [3:0] v
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner: locks onto a pressed key and emits one hex code
// per debounced press, no repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int LOCK_TIMEOUT   = 255,
  parameter int RELEASE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row_sync,
  input  logic [3:0] row_press,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CMAX =
    (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  scan_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [RW-1:0] rel_cnt, rel_d;
  logic [1:0]    lrow, lrow_d;
  logic [3:0]    col_d, code_d, rot;
  logic          valid_d, held_d;

  assign rot = {col[2:0], col[3]};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rel_d   = rel_cnt;
    lrow_d  = lrow;
    col_d   = col;
    code_d  = key_code;
    valid_d = 1'b0;
    held_d  = key_held;
    unique case (state)
      SCAN: begin
        if (cnt >= CW'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          if (|row_sync) begin
            state_d = LOCK;
            lrow_d  = lowest_idx(row_sync);
          end else begin
            col_d = rot;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      LOCK: begin
        // a qualified press beats a same-cycle bounce on the raw row
        if (row_press[lrow]) begin
          state_d = PRESSED;
          valid_d = 1'b1;
          held_d  = 1'b1;
          code_d  = KEY_MAP[lrow][onehot_to_idx(col)];
          rel_d   = '0;
          cnt_d   = '0;
        end else if (!row_sync[lrow] ||
                     cnt >= CW'(LOCK_TIMEOUT - 1)) begin
          state_d = SCAN;
          col_d   = rot;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (|row_sync) begin
          rel_d = '0;
        end else if (rel_cnt >= RW'(RELEASE_CYCLES - 1)) begin
          state_d = SCAN;
          held_d  = 1'b0;
          col_d   = rot;
          rel_d   = '0;
          cnt_d   = '0;
        end else begin
          rel_d = rel_cnt + RW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= SCAN;
      cnt       <= '0;
      rel_cnt   <= '0;
      lrow      <= 2'd0;
      col       <= 4'b0001;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rel_cnt   <= rel_d;
      lrow      <= lrow_d;
      col       <= col_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

endmodule
